// File: rtl/inert_spi_resp_pkg.sv
// Shared widths, frame layout and state encoding for the inertial-sensor
// SPI responder (package spi_resp_pkg).
package spi_resp_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 15;

    // Bit counter: holds 0..FRAME_BITS and saturates there.
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    // Count before the rise that completes the address field.
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(FRAME_BITS - DATA_W - 1);
    // Count at which the read data is loaded into the tx shifter.
    localparam logic [CNT_W-1:0] CNT_DATA_LOAD = CNT_W'(FRAME_BITS - DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } resp_state_t;

    // True when the captured frame asks for a register read.
    function automatic logic frame_is_read(input logic [FRAME_BITS-1:0] frame);
        return frame[RW_BIT];
    endfunction

endpackage

// File: rtl/inert_spi_resp_sync_edge_det.sv
// Input conditioning for the SPI pins: a 2-flop synchronizer with an extra
// history flop that yields single-cycle rise/fall pulses, plus a plain
// 2-flop synchronizer for data lines that need no edge detection.

module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two metastability stages followed by one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Plain two-stage synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/inert_spi_resp.sv
// SPI mode-0 responder for the 16-bit inertial-sensor link.
// Frame: bit 15 R/W (1 = read), bits 14:8 address, bits 7:0 write data.
// Read data is returned on MISO during the second byte of the same frame.
// Optional data-ready interrupt enabled by defining SPI_RESP_INT_EN;
// without it INT is tied low and nxt_smpl is ignored.

module inert_spi_resp
    import spi_resp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frm_done,
    output logic              frm_err,
    input  logic              nxt_smpl,
    output logic              INT
);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic ss_sync;
    logic ss_rise;
    logic ss_fall;
    logic sclk_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_sync;

    // SS_n idles high, so its synchronizer resets high to avoid a false frame start.
    sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (SS_n),
        .sync_o  (ss_sync),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (SCLK),
        .sync_o  (sclk_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (MOSI),
        .sync_o  (mosi_sync)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    resp_state_t             state_q;
    resp_state_t             state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [FRAME_BITS-1:0]   rx_q;
    logic [DATA_W-1:0]       tx_q;
    logic [ADDR_W-1:0]       rd_addr_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [ADDR_W-1:0]       wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q;
    logic [DATA_W-1:0]       wr_data_d;
    logic                    wr_en_q;
    logic                    wr_en_d;
    logic                    frm_done_q;
    logic                    frm_done_d;
    logic                    frm_err_q;
    logic                    frm_err_d;

    // Decoded per-cycle actions. An SS_n rise suppresses any SCLK edge seen
    // in the same cycle, so a racing final edge is never counted.
    logic start_frm;
    logic in_shift;
    logic take_bit;
    logic take_fall;
    logic frame_full;

    assign frame_full = (cnt_q == CNT_FULL);
    // A new frame may start from DONE so an SS_n fall in that cycle is not lost.
    assign start_frm  = ss_fall && ((state_q == IDLE) || (state_q == DONE));
    assign in_shift   = (state_q == SHIFT) && !ss_rise;
    assign take_bit   = in_shift && sclk_rise && !frame_full;
    assign take_fall  = in_shift && sclk_fall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a frame is accepted only if all 16 bits arrived.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = frame_full ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = ss_fall ? SHIFT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: pulses and write fields, registered below for clean outputs.
    always_comb begin
        frm_done_d = 1'b0;
        wr_en_d    = 1'b0;
        frm_err_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (state_q == DONE) begin
            frm_done_d = 1'b1;
            if (!frame_is_read(rx_q)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = rx_q[RW_BIT-1 -: ADDR_W];
                wr_data_d = rx_q[DATA_W-1:0];
            end
        end
        if ((state_q == SHIFT) && ss_rise && !frame_full) begin
            frm_err_d = 1'b1;
        end
    end

    // Output pulse and write-field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_done_q <= 1'b0;
            wr_en_q    <= 1'b0;
            frm_err_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            frm_done_q <= frm_done_d;
            wr_en_q    <= wr_en_d;
            frm_err_q  <= frm_err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Shift datapath: rx captures MOSI on SCLK rises, tx drives MISO and
    // advances on SCLK falls; rd_addr is published once the address is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            rd_addr_q <= '0;
        end else if (start_frm) begin
            cnt_q <= '0;
            rx_q  <= '0;
            tx_q  <= '0;
        end else begin
            if (take_bit) begin
                rx_q  <= {rx_q[FRAME_BITS-2:0], mosi_sync};
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_ADDR_LAST) begin
                    rd_addr_q <= {rx_q[ADDR_W-2:0], mosi_sync};
                end
            end
            if (take_fall) begin
                if (cnt_q == CNT_DATA_LOAD) begin
                    // rx[7] is the R/W bit once eight bits have been shifted in.
                    tx_q <= rx_q[DATA_W-1] ? rd_data : '0;
                end else begin
                    tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional data-ready interrupt
    // ------------------------------------------------------------------
`ifdef SPI_RESP_INT_EN
    logic int_q;

    // Set by a new sample, cleared when a read frame completes; set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b0;
        end else if (nxt_smpl) begin
            int_q <= 1'b1;
        end else if ((state_q == DONE) && frame_is_read(rx_q)) begin
            int_q <= 1'b0;
        end
    end

    assign INT = int_q;
`else
    logic unused_nxt_smpl;
    assign unused_nxt_smpl = nxt_smpl;
    assign INT = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MISO     = ~ss_sync & tx_q[DATA_W-1];
    assign rd_addr  = rd_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign frm_done = frm_done_q;
    assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Self-checking bench for inert_spi_resp. Frames are driven as an SPI
// mode-0 master with clk = 8x SCLK; expected frame outcomes are queued at
// drive time and compared when the responder pulses frm_done/frm_err/wr_en.

module tb_inert_spi_resp;
    import spi_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        nxt_smpl = 1'b0;
    logic        MISO;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frm_done;
    logic        frm_err;
    logic        INT;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ss_rise_cyc = 0;

    typedef struct packed {
        logic       is_err;
        logic       is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    inert_spi_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frm_done (frm_done),
        .frm_err  (frm_err),
        .nxt_smpl (nxt_smpl),
        .INT      (INT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Host register store model.
    function automatic logic [7:0] host_val(input logic [6:0] a);
        if (a == 7'h22) return 8'h5A;
        return {a, 1'b1} ^ 8'h3C;
    endfunction

    assign rd_data = host_val(rd_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [15:0] w, input int nbits);
        exp_t e;
        e.is_err = (nbits < 16);
        e.is_wr  = (nbits >= 16) && !w[15];
        e.addr   = w[14:8];
        e.data   = w[7:0];
        exp_q.push_back(e);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] mw);
        mw = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = (i < 16) ? w[15 - i] : 1'b0;
            tick(4);
            mw = {mw[14:0], MISO};
            SCLK = 1'b1;
            tick(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic begin_frame();
        SS_n = 1'b0;
        tick(5);
    endtask

    task automatic finish_frame(input int gap);
        tick(4);
        SS_n = 1'b1;
        ss_rise_cyc = cyc;
        tick(gap);
    endtask

    task automatic run_frame(input logic [15:0] w, input int nbits, input int gap,
                             input logic chk_miso);
        logic [15:0] mw;
        push_exp(w, nbits);
        begin_frame();
        shift_bits(w, nbits, mw);
        if (nbits >= 16 && w[15]) chk("rd_addr", 32'(rd_addr), 32'(w[14:8]));
        if (chk_miso) chk("miso_word", 32'(mw), w[15] ? {24'h0, host_val(w[14:8])} : 32'h0);
        finish_frame(gap);
    endtask

    task automatic drain();
        tick(8);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: compare each completion pulse against the oldest expected frame.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (frm_done || frm_err || wr_en)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'h0, frm_done, frm_err, wr_en}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frm_err", 32'(frm_err), 32'(mon_e.is_err));
                    chk("frm_done", 32'(frm_done), 32'(!mon_e.is_err));
                    chk("wr_en", 32'(wr_en), 32'(mon_e.is_wr));
                    if (mon_e.is_wr) begin
                        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                    end
                    if (!mon_e.is_err) chk("done_latency", 32'(cyc - ss_rise_cyc), 32'd4);
                    $display("frame cyc=%0d err=%0b done=%0b wr=%0b addr=%02h data=%02h",
                             cyc, frm_err, frm_done, wr_en, wr_addr, wr_data);
                end
            end
        end
    end

    // Watchdog: the run must always reach its summary.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [15:0] mw;
        logic [15:0] rw;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_outs", {27'h0, wr_en, frm_done, frm_err, INT, 1'b0}, 32'h0);
        chk("rst_rd_addr", 32'(rd_addr), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Write frame
        run_frame(16'h0D02, 16, 6, 1'b1);
        drain();

        // Read frame: MISO returns 0x00 then host data 0x5A
        run_frame(16'hA200, 16, 6, 1'b1);
        drain();

        // Abort after 9 bits, then a full frame
        run_frame(16'hA5C3, 9, 6, 1'b0);
        drain();
        run_frame(16'h4C77, 16, 6, 1'b1);
        drain();

        // Reset mid-frame after 5 bits
        begin_frame();
        shift_bits(16'h5555, 5, mw);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {28'h0, wr_en, frm_done, frm_err, MISO}, 32'h0);
        chk("midrst_rd_addr", 32'(rd_addr), 32'h0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
        chk("midrst_wr_data", 32'(wr_data), 32'h0);
        chk("midrst_int", 32'(INT), 32'h0);
        SS_n = 1'b1;
        SCLK = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        run_frame(16'h1234, 16, 6, 1'b1);
        drain();

        // Back-to-back with 4-cycle SS_n gap
        run_frame(16'h3355, 16, 4, 1'b1);
        run_frame(16'h8100, 16, 6, 1'b1);
        drain();

        // SS_n high for one cycle: new frame starts while still in DONE
        run_frame(16'h7F80, 16, 1, 1'b1);
        run_frame(16'hC000, 16, 6, 1'b1);
        drain();

        // Extra SCLK edges beyond 16 are ignored
        run_frame(16'h2A11, 18, 6, 1'b0);
        drain();

        // A few random frames
        for (int k = 0; k < 4; k++) begin
            rw = 16'($urandom);
            run_frame(rw, 16, 6, 1'b1);
            drain();
        end

        // Interrupt behaviour
        nxt_smpl = 1'b1;
        tick(1);
        nxt_smpl = 1'b0;
`ifdef SPI_RESP_INT_EN
        chk("int_set", 32'(INT), 32'h1);
        run_frame(16'h0501, 16, 6, 1'b1);
        drain();
        chk("int_after_write", 32'(INT), 32'h1);
        run_frame(16'h9000, 16, 6, 1'b1);
        drain();
        chk("int_after_read", 32'(INT), 32'h0);
        nxt_smpl = 1'b1;
        tick(1);
        nxt_smpl = 1'b0;
        chk("int_reset_again", 32'(INT), 32'h1);
        // Read frame with nxt_smpl coincident with its frm_done
        push_exp(16'h9100, 16);
        begin_frame();
        shift_bits(16'h9100, 16, mw);
        tick(4);
        SS_n = 1'b1;
        ss_rise_cyc = cyc;
        tick(3);
        nxt_smpl = 1'b1;
        tick(1);
        nxt_smpl = 1'b0;
        chk("int_set_wins_done", 32'(frm_done), 32'h1);
        chk("int_set_wins", 32'(INT), 32'h1);
        drain();
`else
        chk("int_tied_low", 32'(INT), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
